// File: rtl/acc_control_if.sv
// Control bundle between the accumulator control FSM and the IR/accumulator/memory datapath.
// The controller side drives the strobes; the datapath side supplies opcode and status.
interface acc_control_if #(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned ALUOP_W  = 3
);
  logic [OPCODE_W-1:0] opcode;
  logic                acc_zero;
  logic                mem_ready;
  logic                pc_write;
  logic [1:0]          pc_source;
  logic                iord;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                reg_write;
  logic                mem_to_reg;
  logic                alu_src_b;
  logic [ALUOP_W-1:0]  alu_op;
  logic                illegal_op;
  logic                halted;
  logic                fault;

  modport master (
    input  opcode, acc_zero, mem_ready,
    output pc_write, pc_source, iord, mem_read, mem_write, ir_write,
           reg_write, mem_to_reg, alu_src_b, alu_op, illegal_op, halted, fault
  );

  modport slave (
    output opcode, acc_zero, mem_ready,
    input  pc_write, pc_source, iord, mem_read, mem_write, ir_write,
           reg_write, mem_to_reg, alu_src_b, alu_op, illegal_op, halted, fault
  );
endinterface

// File: rtl/acc_control_fsm.sv
// Multi-cycle control unit for the 16-bit accumulator datapath, with a MemReady watchdog.
// Level outputs are registered from the next state; IRWrite/PCWrite/IllegalOp react to live inputs.
module acc_control_fsm #(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned ALUOP_W  = 3,
  parameter int unsigned WAIT_MAX = 15
) (
  input logic           clk,
  input logic           rst,
  acc_control_if.master bus
);

  localparam int unsigned CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;

  localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_SUB   = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_AND   = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_OR    = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_BEQZ  = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_JUMP  = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_HALT  = OPCODE_W'(15);

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMRD, S_MEMWR, S_ALUWB,
    S_LOADWB, S_BRANCH, S_JUMP, S_HALT, S_FAULT
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   wait_cnt, wait_nxt;
  logic               limit_hit;
  logic               req_active;
  logic               fetch_done;

  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic               iord_q, iord_d;
  logic               reg_write_q, reg_write_d;
  logic               mem_to_reg_q, mem_to_reg_d;
  logic               alu_src_b_q, alu_src_b_d;
  logic [ALUOP_W-1:0] alu_op_q, alu_op_d;
  logic [1:0]         pc_source_q, pc_source_d;
  logic               pc_jump_q, pc_jump_d;
  logic               halted_q, halted_d;
  logic               fault_q, fault_d;

  function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
    return op inside {OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_ADDI,
                      OP_AND, OP_OR, OP_BEQZ, OP_JUMP, OP_HALT};
  endfunction

  function automatic logic [ALUOP_W-1:0] alu_op_for(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

  // A memory wait only counts while a request is actually on the bus; the
  // first FETCH cycle after reset has no request yet, so MemReady is ignored there.
  assign req_active = mem_read_q | mem_write_q;
  assign limit_hit  = (WAIT_MAX != 0) && ((32'(wait_cnt) + 32'd1) == WAIT_MAX);

  // Next-state and watchdog counter
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      S_FETCH, S_MEMRD, S_MEMWR: begin
        if (req_active) begin
          if (bus.mem_ready) begin
            wait_nxt = '0;
            case (state)
              S_FETCH: state_nxt = S_DECODE;
              S_MEMRD: state_nxt = (bus.opcode == OP_LOAD) ? S_LOADWB : S_ALUWB;
              default: state_nxt = S_FETCH;
            endcase
          end else if (limit_hit) begin
            state_nxt = S_FAULT;
          end else if (wait_cnt != {CNT_W{1'b1}}) begin
            wait_nxt = wait_cnt + CNT_W'(1);
          end
        end
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR: state_nxt = S_MEMRD;
          OP_STORE: state_nxt = S_MEMWR;
          OP_ADDI:  state_nxt = S_ALUWB;
          OP_BEQZ:  state_nxt = S_BRANCH;
          OP_JUMP:  state_nxt = S_JUMP;
          OP_HALT:  state_nxt = S_HALT;
          default:  state_nxt = S_FETCH;
        endcase
      end
      S_ALUWB, S_LOADWB, S_BRANCH, S_JUMP: state_nxt = S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_FETCH;
    endcase
    if (state_nxt != state) wait_nxt = '0;
  end

  // Level outputs for the state being entered
  always_comb begin
    mem_read_d   = state_nxt inside {S_FETCH, S_MEMRD};
    mem_write_d  = (state_nxt == S_MEMWR);
    iord_d       = state_nxt inside {S_MEMRD, S_MEMWR};
    reg_write_d  = state_nxt inside {S_ALUWB, S_LOADWB};
    mem_to_reg_d = (state_nxt == S_LOADWB);
    alu_src_b_d  = (state_nxt == S_ALUWB) && (bus.opcode == OP_ADDI);
    alu_op_d     = (state_nxt == S_ALUWB) ? alu_op_for(bus.opcode) : ALU_ADD;
    pc_source_d  = (state_nxt == S_BRANCH) ? 2'b01 :
                   (state_nxt == S_JUMP)   ? 2'b10 : 2'b00;
    pc_jump_d    = (state_nxt == S_JUMP);
    halted_d     = (state_nxt == S_HALT);
    fault_d      = (state_nxt == S_FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_FETCH;
      wait_cnt     <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      iord_q       <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_src_b_q  <= 1'b0;
      alu_op_q     <= '0;
      pc_source_q  <= 2'b00;
      pc_jump_q    <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state        <= state_nxt;
      wait_cnt     <= wait_nxt;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      iord_q       <= iord_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_src_b_q  <= alu_src_b_d;
      alu_op_q     <= alu_op_d;
      pc_source_q  <= pc_source_d;
      pc_jump_q    <= pc_jump_d;
      halted_q     <= halted_d;
      fault_q      <= fault_d;
    end
  end

  // Instruction latch and PC+1 fire in the same cycle the fetch completes
  assign fetch_done = (state == S_FETCH) && mem_read_q && bus.mem_ready;

  assign bus.ir_write   = fetch_done;
  assign bus.pc_write   = fetch_done | pc_jump_q | ((state == S_BRANCH) & bus.acc_zero);
  assign bus.illegal_op = (state == S_DECODE) && !is_legal(bus.opcode);
  assign bus.pc_source  = pc_source_q;
  assign bus.iord       = iord_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.reg_write  = reg_write_q;
  assign bus.mem_to_reg = mem_to_reg_q;
  assign bus.alu_src_b  = alu_src_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.halted     = halted_q;
  assign bus.fault      = fault_q;

endmodule

// File: tb/tb_acc_control_fsm.sv
// Bench for acc_control_fsm: directed corner cases, then a random program whose strobe
// events are predicted per instruction into a scoreboard and checked by a monitor.
module tb_acc_control_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  acc_control_if bus ();
  acc_control_fsm dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic       ir;
    logic       pcw;
    logic [1:0] pcs;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       rw;
    logic       m2r;
    logic       srcb;
    logic [2:0] aluop;
    logic       ill;
  } ev_t;

  typedef struct {
    logic [3:0] op;
    logic       az;
    int         fw;
    int         dw;
  } instr_t;

  int     total = 0;
  int     bad   = 0;
  ev_t    exp_q[$];
  instr_t prog[$];
  bit     mon_en = 1'b0;
  bit     run    = 1'b0;
  int     pi, cur, cnt;
  bit     last_fetch;

  function automatic ev_t snap();
    ev_t e;
    e.ir = bus.ir_write;   e.pcw = bus.pc_write;   e.pcs = bus.pc_source;
    e.iord = bus.iord;     e.mr = bus.mem_read;    e.mw = bus.mem_write;
    e.rw = bus.reg_write;  e.m2r = bus.mem_to_reg; e.srcb = bus.alu_src_b;
    e.aluop = bus.alu_op;  e.ill = bus.illegal_op;
    return e;
  endfunction

  function automatic logic strobe_seen();
    return bus.ir_write | bus.pc_write | bus.reg_write | bus.mem_write | bus.illegal_op;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Reference: the strobe events one instruction produces, in order
  task automatic predict(input instr_t in);
    ev_t e;
    e = '0; e.ir = 1'b1; e.pcw = 1'b1; e.mr = 1'b1;
    exp_q.push_back(e);
    e = '0;
    case (in.op)
      4'h0: begin e.rw = 1'b1; e.m2r = 1'b1; exp_q.push_back(e); end
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
        e.rw    = 1'b1;
        e.srcb  = (in.op == 4'h4);
        e.aluop = (in.op == 4'h3) ? 3'd1 : (in.op == 4'h5) ? 3'd2 : (in.op == 4'h6) ? 3'd3 : 3'd0;
        exp_q.push_back(e);
      end
      4'h1: begin
        e.mw = 1'b1; e.iord = 1'b1;
        for (int k = 0; k <= in.dw; k++) exp_q.push_back(e);
      end
      4'h7: if (in.az) begin e.pcw = 1'b1; e.pcs = 2'b01; exp_q.push_back(e); end
      4'h8: begin e.pcw = 1'b1; e.pcs = 2'b10; exp_q.push_back(e); end
      default: begin e.ill = 1'b1; exp_q.push_back(e); end
    endcase
  endtask

  initial begin
    int n;
    ev_t e;
    bus.opcode = 4'h0;
    bus.acc_zero = 1'b0;
    bus.mem_ready = 1'b0;

    // Scoreboard monitor
    fork
      forever begin
        @(negedge clk);
        if (mon_en && strobe_seen()) begin
          if (exp_q.size() == 0) check("sb_unexpected", 32'(snap()), 32'd0);
          else begin
            e = exp_q.pop_front();
            check("sb_event", 32'(snap()), 32'(e));
          end
        end
      end
    join_none

    // Memory responder for the random program
    fork
      forever begin
        @(posedge clk);
        #1;
        if (run) begin
          if (bus.mem_ready) begin
            bus.mem_ready = 1'b0;
            if (last_fetch && pi < prog.size()) begin
              bus.opcode = prog[pi].op;
              bus.acc_zero = prog[pi].az;
              cur = pi;
              pi++;
            end
            cnt = -1;
          end else if (bus.mem_read || bus.mem_write) begin
            if (cnt < 0) cnt = bus.iord ? prog[cur].dw : ((pi < prog.size()) ? prog[pi].fw : 1000);
            if (cnt == 0) begin
              bus.mem_ready = 1'b1;
              last_fetch = !bus.iord;
            end else cnt--;
          end
        end
      end
    join_none

    // Reset mid-MEMWR drops MemWrite without a clock edge
    do_reset();
    bus.opcode = 4'h1;
    tick();
    check("release_memread", 32'(bus.mem_read), 32'd1);
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    tick();
    check("memwr_active", 32'(bus.mem_write), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_memwrite_drop", 32'(bus.mem_write), 32'd0);
    check("reset_outputs", 32'({bus.mem_read, bus.iord, bus.halted, bus.fault, bus.ir_write, bus.pc_write}), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("fetch_after_reset", 32'({bus.mem_read, bus.iord}), 32'b10);

    // LOAD with MemReady tied high
    do_reset();
    bus.opcode = 4'h0;
    bus.mem_ready = 1'b1;
    tick();
    check("load_c1_irpc", 32'({bus.ir_write, bus.pc_write, bus.pc_source}), 32'b1100);
    tick();
    check("load_c2_decode", 32'({bus.ir_write, bus.reg_write, bus.mem_read, bus.mem_write, bus.pc_write}), 32'd0);
    tick();
    check("load_c3_memrd", 32'({bus.mem_read, bus.iord}), 32'b11);
    tick();
    check("load_c4_wb", 32'({bus.reg_write, bus.mem_to_reg}), 32'b11);
    tick();
    check("load_latency4", 32'(bus.ir_write), 32'd1);

    // ADDI then SUB
    bus.opcode = 4'h4;
    tick(); tick();
    check("addi_wb", 32'({bus.reg_write, bus.alu_src_b, bus.alu_op}), 32'b11000);
    tick();
    check("addi_latency3", 32'(bus.ir_write), 32'd1);
    bus.opcode = 4'h3;
    tick(); tick(); tick();
    check("sub_wb", 32'({bus.reg_write, bus.alu_src_b, bus.alu_op, bus.mem_to_reg}), 32'b100010);
    tick();

    // BEQZ taken / not taken, JUMP
    bus.opcode = 4'h7; bus.acc_zero = 1'b1;
    tick(); tick();
    check("beqz_taken", 32'({bus.pc_write, bus.pc_source}), 32'b101);
    tick();
    bus.acc_zero = 1'b0;
    tick(); tick();
    check("beqz_not_taken", 32'({bus.pc_write, bus.pc_source}), 32'b001);
    tick();
    bus.opcode = 4'h8;
    tick(); tick();
    check("jump", 32'({bus.pc_write, bus.pc_source}), 32'b110);
    tick();

    // STORE with three wait cycles
    bus.opcode = 4'h1;
    tick();
    bus.mem_ready = 1'b0;
    tick();
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) bus.mem_ready = 1'b1;
      if (i == 4) bus.mem_ready = 1'b0;
      if (bus.mem_write && bus.iord) n++;
      tick();
    end
    check("store_memwrite_cycles", 32'(n), 32'd4);
    check("store_back_to_fetch", 32'({bus.mem_read, bus.iord}), 32'b10);

    // Illegal opcode and HALT
    bus.opcode = 4'hA;
    bus.mem_ready = 1'b1;
    tick();
    check("illegal_pulse", 32'(bus.illegal_op), 32'd1);
    tick();
    check("illegal_to_fetch", 32'({bus.illegal_op, bus.mem_read, bus.ir_write}), 32'b011);
    bus.opcode = 4'hF;
    tick(); tick();
    n = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.halted && !bus.mem_read && !bus.ir_write && !bus.pc_write) n++;
      tick();
    end
    check("halt_sticky50", 32'(n), 32'd50);

    // Watchdog fault on a hung fetch
    do_reset();
    tick();
    repeat (14) tick();
    check("wdog_before_limit", 32'({bus.fault, bus.mem_read}), 32'b01);
    tick();
    check("wdog_fault", 32'({bus.fault, bus.mem_read}), 32'b10);

    // MemReady on the limit cycle completes the fetch
    do_reset();
    tick();
    repeat (14) tick();
    bus.mem_ready = 1'b1;
    #1;
    check("limit_ready_irwrite", 32'(bus.ir_write), 32'd1);
    tick();
    bus.mem_ready = 1'b0;
    check("limit_ready_no_fault", 32'(bus.fault), 32'd0);

    // Random program against the scoreboard
    do_reset();
    prog.delete();
    exp_q.delete();
    for (int i = 0; i < 60; i++) begin
      instr_t in;
      in.op = 4'($urandom_range(0, 14));
      in.az = 1'($urandom_range(0, 1));
      in.fw = $urandom_range(0, 3);
      in.dw = $urandom_range(0, 3);
      prog.push_back(in);
      predict(in);
    end
    pi = 0; cur = 0; cnt = -1; last_fetch = 1'b0;
    mon_en = 1'b1;
    run = 1'b1;
    for (int c = 0; c < 5000 && exp_q.size() != 0; c++) tick();
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    repeat (5) tick();
    mon_en = 1'b0;
    run = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
